// File: rtl/rgbw_frame_sched_if.sv
// FIFO write-side bundle between rgbw_frame_sched and async_fifo.
// Master pushes pixel words; slave reports full/empty.
interface rgbw_frame_sched_if #(
  parameter int DATA_SIZE = 32
);
  logic                 fifo_w_en;
  logic [DATA_SIZE-1:0] fifo_w_data;
  logic                 fifo_w_full;
  logic                 fifo_empty;

  modport master (
    output fifo_w_en,
    output fifo_w_data,
    input  fifo_w_full,
    input  fifo_empty
  );

  modport slave (
    input  fifo_w_en,
    input  fifo_w_data,
    output fifo_w_full,
    output fifo_empty
  );
endinterface

// File: rtl/rgbw_frame_sched.sv
// SK6812RGBW frame scheduler: double-buffered pixel memory pushed
// into async_fifo once per start pulse or at a fixed frame period.
module rgbw_frame_sched #(
  parameter int DATA_SIZE  = 32,
  parameter int NUM_LEDS   = 64,
  parameter int IDX_W      = 8,
  parameter int LATCH_CLKS = 7800,
  parameter int FRAME_CLKS = 960000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 host_we,
  input  logic [IDX_W-1:0]     host_addr,
  input  logic [DATA_SIZE-1:0] host_data,
  input  logic                 swap_req,
  input  logic                 start,
  input  logic                 run,
  rgbw_frame_sched_if.master   fifo,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun,
  output logic                 front_bank
);

  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int PW = $clog2(FRAME_CLKS);
  localparam int LW = (LATCH_CLKS > 1) ? $clog2(LATCH_CLKS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DRAIN,
    LATCH,
    WAIT
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [PW-1:0]        period_cnt;
  logic [LW-1:0]        latch_cnt;
  logic                 swap_pend;
  logic                 w_en;
  logic [DATA_SIZE-1:0] w_data;
  logic                 go;
  logic                 wr;
  logic                 last;
  logic                 per_sat;
  logic                 per_end;
  logic                 lat_end;
  logic                 addr_ok;

  logic [DATA_SIZE-1:0] mem [2][NUM_LEDS];

  assign go      = start | run;
  assign wr      = (state == FILL) && !fifo.fifo_w_full;
  assign last    = idx == IDX_W'(NUM_LEDS - 1);
  assign per_sat = period_cnt == PW'(FRAME_CLKS - 1);
  // IDLE costs one cycle, so the period ends one count early
  // to keep frame starts exactly FRAME_CLKS apart.
  assign per_end = period_cnt >= PW'(FRAME_CLKS - 2);
  assign lat_end = latch_cnt == LW'(LATCH_CLKS - 1);
  assign addr_ok = {1'b0, host_addr} < (IDX_W + 1)'(NUM_LEDS);

  assign busy             = state != IDLE;
  assign fifo.fifo_w_en   = w_en;
  assign fifo.fifo_w_data = w_data;

  // Host writes only ever touch the back bank.
  always_ff @(posedge clk) begin
    if (host_we && addr_ok)
      mem[~front_bank][host_addr[AW-1:0]] <= host_data;
  end

  // Next state, FIFO write strobe and frame_done pulse.
  always_comb begin
    state_nxt  = state;
    w_en       = 1'b0;
    w_data     = '0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (go)
          state_nxt = FILL;
      end
      FILL: begin
        w_en   = !fifo.fifo_w_full;
        w_data = mem[front_bank][idx[AW-1:0]];
        if (wr && last)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (fifo.fifo_empty)
          state_nxt = LATCH;
      end
      LATCH: begin
        if (lat_end) begin
          frame_done = 1'b1;
          if (!run || per_end)
            state_nxt = IDLE;
          else
            state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!run || per_end)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters, bank select and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      period_cnt <= '0;
      latch_cnt  <= '0;
      swap_pend  <= 1'b0;
      front_bank <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && go) begin
        idx        <= '0;
        period_cnt <= '0;
      end else begin
        if (wr)
          idx <= idx + 1'b1;
        if (state != IDLE && !per_sat)
          period_cnt <= period_cnt + 1'b1;
      end
      // A request arriving on the swap cycle itself stays pending.
      if (state == IDLE && go && swap_pend) begin
        front_bank <= ~front_bank;
        swap_pend  <= swap_req;
      end else if (swap_req) begin
        swap_pend <= 1'b1;
      end
      if (state == DRAIN)
        latch_cnt <= '0;
      else if (state == LATCH)
        latch_cnt <= latch_cnt + 1'b1;
      if (per_sat && run &&
          (state == FILL || state == DRAIN || state == LATCH))
        overrun <= 1'b1;
    end
  end

endmodule
